// File: rtl/ctrl_pipe_tracker.sv
// ctrl_pipe_tracker: instruction/valid tracking pipeline for the control path.
// Stage-selective stall with bubble injection, front flush, saturating counters.
module ctrl_pipe_tracker #(
  parameter int IW = 16,
  parameter int DEPTH = 5,
  parameter int SW = 3,
  parameter logic [IW-1:0] NOP = 16'hE800,
  parameter int FLUSH_STAGES = 2,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IW-1:0]         instr_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall_req,
  input  logic [SW-1:0]         stall_stage,
  input  logic                  flush,
  output logic [IW*DEPTH-1:0]   stage_instr,
  output logic [DEPTH-1:0]      stage_valid,
  output logic [CW-1:0]         bubble_count,
  output logic [CW-1:0]         flush_count
);

  logic [IW-1:0] w_q [DEPTH];
  logic [IW-1:0] w_n [DEPTH];
  logic [IW-1:0] pw  [DEPTH];
  logic [DEPTH-1:0] v_q, v_n, pv;
  logic [SW-1:0] k_eff;
  logic st_eff, bub_inc;
  int kk;

  // Next-state selection for every stage: flush > stall > advance
  always_comb begin
    st_eff = stall_req & (stall_stage != '0);
    in_ready = !(st_eff & !flush);
    k_eff = (stall_stage > SW'(DEPTH)) ? SW'(DEPTH) : stall_stage;
    kk = 32'(k_eff);
    bub_inc = st_eff & !flush & (kk < DEPTH);
    pw[0] = instr_in;
    pv[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      pw[i] = w_q[i-1];
      pv[i] = v_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_n[i] = pw[i];
      v_n[i] = pv[i];
      if (flush) begin
        if (i < FLUSH_STAGES) begin
          w_n[i] = NOP;
          v_n[i] = 1'b0;
        end
      end else if (st_eff) begin
        if (i < kk) begin
          w_n[i] = w_q[i];
          v_n[i] = v_q[i];
        end else if (i == kk) begin
          w_n[i] = NOP;
          v_n[i] = 1'b0;
        end
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) w_q[i] <= NOP;
      v_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) w_q[i] <= w_n[i];
      v_q <= v_n;
    end
  end

  // Saturating bubble and flush event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
      flush_count <= '0;
    end else begin
      if (bub_inc && bubble_count != '1)
        bubble_count <= bubble_count + CW'(1);
      if (flush && flush_count != '1)
        flush_count <= flush_count + CW'(1);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign stage_instr[g*IW +: IW] = w_q[g];
  end
  assign stage_valid = v_q;

endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
// tb_ctrl_pipe_tracker: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_ctrl_pipe_tracker;

  localparam logic [15:0] N = 16'hE800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, stall_req, flush, in_ready;
  logic [15:0] instr_in;
  logic [2:0] stall_stage;
  logic [79:0] stage_instr;
  logic [4:0] stage_valid;
  logic [15:0] bubble_count, flush_count;

  logic rst2, in_valid2, stall_req2, flush2, in_ready2;
  logic [15:0] instr_in2;
  logic [2:0] stall_stage2;
  logic [79:0] stage_instr2;
  logic [4:0] stage_valid2;
  logic [3:0] bubble_count2, flush_count2;

  ctrl_pipe_tracker dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .in_valid(in_valid),
    .in_ready(in_ready), .stall_req(stall_req), .stall_stage(stall_stage),
    .flush(flush), .stage_instr(stage_instr), .stage_valid(stage_valid),
    .bubble_count(bubble_count), .flush_count(flush_count)
  );

  ctrl_pipe_tracker #(.CW(4)) dut2 (
    .clk(clk), .rst(rst2), .instr_in(instr_in2), .in_valid(in_valid2),
    .in_ready(in_ready2), .stall_req(stall_req2), .stall_stage(stall_stage2),
    .flush(flush2), .stage_instr(stage_instr2), .stage_valid(stage_valid2),
    .bubble_count(bubble_count2), .flush_count(flush_count2)
  );

  typedef struct {
    string name;
    int sel;
    logic [79:0] exp;
  } chk_t;

  chk_t sbq[$];
  int total = 0;
  int passed = 0;

  function automatic logic [79:0] pk(logic [15:0] s1, logic [15:0] s2,
                                     logic [15:0] s3, logic [15:0] s4,
                                     logic [15:0] s5);
    return {s5, s4, s3, s2, s1};
  endfunction

  task automatic expect_v(string name, int sel, logic [79:0] v);
    chk_t c;
    c.name = name;
    c.sel = sel;
    c.exp = v;
    sbq.push_back(c);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the DUT at negedge
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      chk_t c;
      logic [79:0] act;
      c = sbq.pop_front();
      case (c.sel)
        0: act = stage_instr;
        1: act = 80'(stage_valid);
        2: act = 80'(bubble_count);
        3: act = 80'(flush_count);
        4: act = 80'(in_ready);
        5: act = 80'(bubble_count2);
        default: act = 80'(stage_valid2);
      endcase
      total++;
      if (act === c.exp) passed++;
      else $display("FAIL %s: got %h want %h", c.name, act, c.exp);
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    instr_in = '0; in_valid = 1'b0; stall_req = 1'b0;
    stall_stage = '0; flush = 1'b0;
    instr_in2 = '0; in_valid2 = 1'b0; stall_req2 = 1'b0;
    stall_stage2 = '0; flush2 = 1'b0;
    step(2);
    expect_v("rst_instr", 0, pk(N, N, N, N, N));
    expect_v("rst_valid", 1, 80'h0);
    expect_v("rst_bub", 2, 80'h0);
    expect_v("rst_flush", 3, 80'h0);
    rst = 1'b0;

    for (int i = 1; i <= 6; i++) begin
      instr_in = 16'(i);
      in_valid = 1'b1;
      step(1);
    end
    expect_v("fill_instr", 0, pk(6, 5, 4, 3, 2));
    expect_v("fill_valid", 1, 80'h1F);
    expect_v("fill_bub", 2, 80'h0);

    instr_in = 16'h0007;
    stall_req = 1'b1;
    stall_stage = 3'd2;
    expect_v("stall_rdy0", 4, 80'h0);
    step(2);
    expect_v("stall_instr", 0, pk(6, 5, N, N, 4));
    expect_v("stall_valid", 1, 80'h13);
    expect_v("stall_bub", 2, 80'h2);
    stall_req = 1'b0;
    expect_v("rel_rdy", 4, 80'h1);
    step(1);
    expect_v("rel_instr", 0, pk(7, 6, 5, N, N));
    expect_v("rel_valid", 1, 80'h07);

    instr_in = 16'h0008;
    stall_req = 1'b1;
    stall_stage = 3'd5;
    expect_v("frz_rdy", 4, 80'h0);
    step(1);
    expect_v("frz_instr", 0, pk(7, 6, 5, N, N));
    expect_v("frz_valid", 1, 80'h07);
    expect_v("frz_bub", 2, 80'h2);
    stall_stage = 3'd0;
    expect_v("s0_rdy", 4, 80'h1);
    step(1);
    expect_v("s0_instr", 0, pk(8, 7, 6, 5, N));
    expect_v("s0_valid", 1, 80'h0F);
    expect_v("s0_bub", 2, 80'h2);

    stall_req = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      instr_in = 16'(i);
      step(1);
    end
    expect_v("refill", 0, pk(6, 5, 4, 3, 2));
    flush = 1'b1;
    stall_req = 1'b1;
    stall_stage = 3'd2;
    instr_in = 16'h0009;
    expect_v("fl_rdy", 4, 80'h1);
    step(1);
    expect_v("fl_instr", 0, pk(N, N, 5, 4, 3));
    expect_v("fl_valid", 1, 80'h1C);
    expect_v("fl_cnt", 3, 80'h1);
    expect_v("fl_bub", 2, 80'h2);
    stall_req = 1'b0;
    step(2);
    expect_v("fl3_instr", 0, pk(N, N, N, N, 5));
    expect_v("fl3_valid", 1, 80'h10);
    expect_v("fl3_cnt", 3, 80'h3);
    flush = 1'b0;

    instr_in = 16'h000A;
    stall_req = 1'b1;
    stall_stage = 3'd1;
    step(1);
    #1 rst = 1'b1;
    expect_v("arst_instr", 0, pk(N, N, N, N, N));
    expect_v("arst_valid", 1, 80'h0);
    expect_v("arst_bub", 2, 80'h0);
    expect_v("arst_flush", 3, 80'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    stall_req = 1'b0;
    instr_in = 16'h00AB;
    in_valid = 1'b1;
    step(1);
    expect_v("post_instr", 0, pk(16'h00AB, N, N, N, N));
    expect_v("post_valid", 1, 80'h01);
    expect_v("post_rdy", 4, 80'h1);

    rst2 = 1'b0;
    stall_req2 = 1'b1;
    stall_stage2 = 3'd1;
    step(10);
    expect_v("sat_mid", 5, 80'hA);
    step(10);
    expect_v("sat_top", 5, 80'hF);
    expect_v("sat_valid", 6, 80'h0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
